// File: rtl/ball_launcher_pkg.sv
// rtl/ball_launcher_pkg.sv - shared game-state encoding, hole count and launcher FSM type
package ball_launcher_pkg;

  localparam logic [2:0] GS_RESET = 3'd0;
  localparam logic [2:0] GS_WAIT  = 3'd1;
  localparam logic [2:0] GS_START = 3'd2;
  localparam logic [2:0] GS_GET   = 3'd3;
  localparam logic [2:0] GS_OVER  = 3'd4;

  localparam int NUM_HOLES = 8;

  typedef enum logic [1:0] {
    L_IDLE,
    L_OPEN,
    L_CLOSE,
    L_FLIGHT
  } launch_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ball_launcher_if.sv
// rtl/ball_launcher_if.sv - game-state, button and hole inputs plus launcher status outputs
interface ball_launcher_if;
  import ball_launcher_pkg::*;

  logic [2:0]           state;
  logic                 launch_req;
  logic [NUM_HOLES-1:0] ball;
  logic                 servo_pwm;
  logic                 busy;
  logic                 launched;
  logic [3:0]           balls_left;
  logic                 empty;

  modport master (
    output state, launch_req, ball,
    input  servo_pwm, busy, launched, balls_left, empty
  );

  modport slave (
    input  state, launch_req, ball,
    output servo_pwm, busy, launched, balls_left, empty
  );

endinterface

// File: rtl/ball_launcher_servo_pwm.sv
// rtl/ball_launcher_servo_pwm.sv - servo frame generator with width latched at frame start
module ball_launcher_servo_pwm #(
  parameter  int PWM_PERIOD = 2_000_000,
  localparam int WW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [WW-1:0] width_i,
  output logic          pwm_o
);

  localparam logic [WW-1:0] CNT_LAST = WW'(PWM_PERIOD - 1);

  logic [WW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] width_q, width_d;
  logic          pwm_q, pwm_d;

  // The new width is only sampled when the counter sits at 0 so no frame is ever truncated.
  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + WW'(1);
    width_d = (cnt_q == '0) ? width_i : width_q;
    pwm_d   = (cnt_q < width_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      width_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/ball_launcher.sv
// rtl/ball_launcher.sv - releases one ball per accepted request and waits for a hole hit or timeout
module ball_launcher
  import ball_launcher_pkg::*;
#(
  parameter int NUM_BALLS      = 8,
  parameter int PWM_PERIOD     = 2_000_000,
  parameter int PW_CLOSED      = 100_000,
  parameter int PW_OPEN        = 200_000,
  parameter int OPEN_CYC       = 30_000_000,
  parameter int SETTLE_CYC     = 20_000_000,
  parameter int FLIGHT_TIMEOUT = 300_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  ball_launcher_if.slave bus
);

  localparam int TW = $clog2(max3(OPEN_CYC, SETTLE_CYC, FLIGHT_TIMEOUT) + 1);
  localparam int WW = $clog2(PWM_PERIOD + 1);

  localparam logic [TW-1:0] OPEN_LAST   = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] FLIGHT_LAST = TW'(FLIGHT_TIMEOUT - 1);
  localparam logic [3:0]    BALLS_FULL  = 4'(NUM_BALLS);

  launch_state_e st_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    balls_q;
  logic          hit_q;
  logic          busy_q;
  logic          launched_q;
  logic [WW-1:0] pwm_width;
  logic          ball_seen;
  logic          accept;

  assign ball_seen = |bus.ball;
  assign accept    = bus.launch_req && (bus.state == GS_START) && (balls_q != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= L_IDLE;
      timer_q    <= '0;
      balls_q    <= BALLS_FULL;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      launched_q <= 1'b0;
    end else begin
      launched_q <= 1'b0;
      if (bus.state == GS_RESET) begin
        st_q    <= L_IDLE;
        timer_q <= '0;
        balls_q <= BALLS_FULL;
        hit_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (st_q)
          L_IDLE: begin
            hit_q <= 1'b0;
            if (accept) begin
              st_q       <= L_OPEN;
              timer_q    <= '0;
              balls_q    <= balls_q - 4'd1;
              busy_q     <= 1'b1;
              launched_q <= 1'b1;
            end
          end
          L_OPEN: begin
            if (ball_seen) hit_q <= 1'b1;
            if (timer_q == OPEN_LAST) begin
              st_q    <= L_CLOSE;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          L_CLOSE: begin
            if (ball_seen) hit_q <= 1'b1;
            if (timer_q == SETTLE_LAST) begin
              st_q    <= L_FLIGHT;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          L_FLIGHT: begin
            // A lost ball (timeout) is not credited back to balls_left.
            if (ball_seen || hit_q || (timer_q == FLIGHT_LAST)) begin
              st_q    <= L_IDLE;
              timer_q <= '0;
              hit_q   <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          default: begin
            st_q    <= L_IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pwm_width = (st_q == L_OPEN) ? WW'(PW_OPEN) : WW'(PW_CLOSED);
  end

  ball_launcher_servo_pwm #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_servo (
    .clk    (clk),
    .rst_n  (rst_n),
    .width_i(pwm_width),
    .pwm_o  (bus.servo_pwm)
  );

  assign bus.busy       = busy_q;
  assign bus.launched   = launched_q;
  assign bus.balls_left = balls_q;
  assign bus.empty      = (balls_q == 4'd0);

endmodule

// File: tb/tb_ball_launcher.sv
// tb/tb_ball_launcher.sv - directed self-checking bench for ball_launcher
module tb_ball_launcher;
  import ball_launcher_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   hi;

  ball_launcher_if bif ();

  ball_launcher #(
    .NUM_BALLS     (8),
    .PWM_PERIOD    (20),
    .PW_CLOSED     (2),
    .PW_OPEN       (4),
    .OPEN_CYC      (40),
    .SETTLE_CYC    (20),
    .FLIGHT_TIMEOUT(100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  // Edges since reset release; mod 20 tracks the servo frame phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      if (bif.servo_pwm === 1'b1) h++;
      @(negedge clk);
    end
  endtask

  task automatic wait_phase();
    int guard = 0;
    while ((cyc % 20) != 19 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("phase_bound", cyc % 20, 19);
  endtask

  task automatic launch(input string tag);
    bif.launch_req = 1'b1;
    @(negedge clk);
    bif.launch_req = 1'b0;
    check(tag, bif.launched, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    bif.state      = GS_WAIT;
    bif.launch_req = 1'b0;
    bif.ball       = '0;
    #12;
    check("rst_busy",     bif.busy, 0);
    check("rst_launched", bif.launched, 0);
    check("rst_pwm",      bif.servo_pwm, 0);
    check("rst_balls",    bif.balls_left, 8);
    check("rst_empty",    bif.empty, 0);

    // 1: idle frames
    @(negedge clk);
    rst_n = 1'b1;
    count_high(20, hi);
    check("idle_pwm", hi, 2);
    check("idle_balls", bif.balls_left, 8);
    check("idle_busy",  bif.busy, 0);

    // 2: aligned launch, gate open frames then closed, hit in FLIGHT
    bif.state = GS_START;
    wait_phase();
    launch("t2_launched");
    check("t2_balls", bif.balls_left, 7);
    check("t2_busy",  bif.busy, 1);
    @(negedge clk);
    check("t2_launched_once", bif.launched, 0);
    count_high(20, hi);
    check("t2_open_frame1", hi, 4);
    count_high(20, hi);
    check("t2_open_frame2", hi, 4);
    count_high(20, hi);
    check("t2_close_frame", hi, 2);
    check("t2_flight_busy", bif.busy, 1);
    bif.ball = 8'h04;
    @(negedge clk);
    bif.ball = '0;
    check("t2_hit_idle", bif.busy, 0);
    check("t2_balls_after", bif.balls_left, 7);

    // 3: no ball -> timeout after 100 FLIGHT cycles
    launch("t3_launched");
    repeat (159) @(negedge clk);
    check("t3_busy_before_timeout", bif.busy, 1);
    @(negedge clk);
    check("t3_busy_after_timeout", bif.busy, 0);
    check("t3_balls", bif.balls_left, 6);

    // 4: requests while busy or outside START are dropped
    launch("t4_launched");
    repeat (5) @(negedge clk);
    bif.launch_req = 1'b1;
    @(negedge clk);
    bif.launch_req = 1'b0;
    check("t4_busy_req_launched", bif.launched, 0);
    check("t4_busy_req_balls", bif.balls_left, 5);
    repeat (55) @(negedge clk);
    bif.ball = 8'h80;
    @(negedge clk);
    bif.ball = '0;
    check("t4_idle", bif.busy, 0);
    bif.state = GS_WAIT;
    bif.launch_req = 1'b1;
    @(negedge clk);
    bif.launch_req = 1'b0;
    check("t4_wait_launched", bif.launched, 0);
    check("t4_wait_busy", bif.busy, 0);
    check("t4_wait_balls", bif.balls_left, 5);

    // 5: reload, eight launches to empty, ninth dropped, reload
    bif.state = GS_RESET;
    @(negedge clk);
    bif.state = GS_START;
    check("t5_reload", bif.balls_left, 8);
    for (int n = 0; n < 8; n++) begin
      launch("t5_launched");
      repeat (61) @(negedge clk);
      bif.ball = 8'h80;
      @(negedge clk);
      bif.ball = '0;
      check("t5_idle", bif.busy, 0);
    end
    check("t5_balls_zero", bif.balls_left, 0);
    check("t5_empty", bif.empty, 1);
    bif.launch_req = 1'b1;
    @(negedge clk);
    bif.launch_req = 1'b0;
    check("t5_ninth_launched", bif.launched, 0);
    check("t5_ninth_busy", bif.busy, 0);
    check("t5_ninth_balls", bif.balls_left, 0);
    bif.state = GS_RESET;
    @(negedge clk);
    bif.state = GS_START;
    check("t5_reset_balls", bif.balls_left, 8);
    check("t5_reset_empty", bif.empty, 0);

    // 6: hit during OPEN is remembered; async reset mid-OPEN
    launch("t6_launched");
    repeat (10) @(negedge clk);
    bif.ball = 8'h01;
    @(negedge clk);
    bif.ball = '0;
    repeat (49) @(negedge clk);
    check("t6_flight_entered", bif.busy, 1);
    @(negedge clk);
    check("t6_flight_first_cycle_exit", bif.busy, 0);
    wait_phase();
    launch("t6_launched2");
    repeat (2) @(negedge clk);
    check("t6_pwm_high_open", bif.servo_pwm, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pwm",   bif.servo_pwm, 0);
    check("t6_rst_busy",  bif.busy, 0);
    check("t6_rst_balls", bif.balls_left, 8);
    @(negedge clk);
    rst_n = 1'b1;
    count_high(20, hi);
    check("t6_idle_pwm", hi, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
